sma_tdm_scheduler: RTL and testbench

//  Time-multiplexes one DS2 moving-average datapath (4-tap SMA, y=(x[n]+..+x[n-3])/4) across
//  N_CH sample streams. Round-robin arbitrates per-channel valid/ready requests, keeps per-channel

---
 rtl/sma_pkg.sv | 18 +
 rtl/sma_tdm_scheduler_if.sv | 28 ++
 rtl/sma_ds2_core.sv | 27 ++
 rtl/sma_tdm_scheduler.sv | 104 ++++++++++
 tb/tb_sma_tdm_scheduler.sv | 159 +++++++++++++++
 5 files changed

// File: rtl/sma_pkg.sv
// Shared types and constants for the time-multiplexed 4-tap moving-average scheduler.
package sma_pkg;

    localparam int SAMPLE_W  = 16;
    localparam int DIV_SHIFT = 2;

    typedef logic signed [SAMPLE_W-1:0] sample_t;
    typedef logic signed [SAMPLE_W:0]   s0_t;
    typedef logic signed [SAMPLE_W+1:0] sum_t;

    // Per-channel history: previous sample, previous pair sum, pair sum from two samples ago.
    typedef struct packed {
        sample_t xp1;
        s0_t     s0p1;
        s0_t     s2;
    } hist_t;

endpackage

// File: rtl/sma_tdm_scheduler_if.sv
// Multi-channel sample input and tagged result output of the scheduler.
interface sma_tdm_scheduler_if
    import sma_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
);
    logic [N_CH-1:0]          in_valid;
    logic [N_CH-1:0]          in_ready;
    logic [SAMPLE_W*N_CH-1:0] in_data;
    logic [N_CH-1:0]          clr;
    logic                     out_valid;
    logic                     out_ready;
    logic [CH_W-1:0]          out_ch;
    sample_t                  out_data;

    // Producer / consumer side (front end plus downstream sink).
    modport master (
        output in_valid, in_data, clr, out_ready,
        input  in_ready, out_valid, out_ch, out_data
    );

    // Scheduler side.
    modport slave (
        input  in_valid, in_data, clr, out_ready,
        output in_ready, out_valid, out_ch, out_data
    );
endinterface

// File: rtl/sma_ds2_core.sv
// Combinational 4-tap moving-average step built from two pairwise sums.
module sma_ds2_core
    import sma_pkg::*;
(
    input  sample_t x,
    input  hist_t   hist,
    output sample_t y,
    output hist_t   hist_next
);
    s0_t  s0;
    sum_t sum;
    sum_t sum_adj;

    // Pair sum, full 4-tap sum, divide by 4 rounding toward zero.
    always_comb begin
        s0      = s0_t'(x) + s0_t'(hist.xp1);
        sum     = sum_t'(s0) + sum_t'(hist.s2);
        // Bias negative sums by 3 so the arithmetic shift truncates toward zero.
        sum_adj = sum + (sum[SAMPLE_W+1] ? sum_t'(3) : sum_t'(0));
        // |sum/4| <= 32768, so the quotient always fits the 16-bit result.
        y       = sample_t'(sum_adj >>> DIV_SHIFT);

        hist_next.xp1  = x;
        hist_next.s0p1 = s0;
        hist_next.s2   = hist.s0p1;
    end
endmodule

// File: rtl/sma_tdm_scheduler.sv
// Round-robin scheduler sharing one moving-average datapath across N_CH sample streams.
module sma_tdm_scheduler
    import sma_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int CH_W = 2
)(
    input logic               clk,
    input logic               rst,
    sma_tdm_scheduler_if.slave bus
);
    hist_t           hist_reg [N_CH];
    logic [CH_W-1:0] rr_last_reg;
    logic            out_valid_reg;
    logic [CH_W-1:0] out_ch_reg;
    sample_t         out_data_reg;

    logic            can_acc;
    logic            grant_any;
    logic [CH_W-1:0] grant_idx;
    logic [N_CH-1:0] grant_vec;
    sample_t         x_sel;
    hist_t           hist_sel;
    hist_t           hist_upd;
    sample_t         y;

    // Round-robin search starting one past the last granted channel; blocked while output is stalled.
    always_comb begin
        int              idx;
        logic [CH_W-1:0] idx_c;
        idx       = 0;
        idx_c     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        can_acc   = !out_valid_reg || bus.out_ready;
        if (can_acc && rst) begin
            for (int i = 0; i < N_CH; i++) begin
                idx = int'(rr_last_reg) + 1 + i;
                if (idx >= N_CH) idx = idx - N_CH;
                idx_c = CH_W'(idx);
                if (!grant_any && bus.in_valid[idx_c]) begin
                    grant_any = 1'b1;
                    grant_idx = idx_c;
                end
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ready
            assign grant_vec[gi] = grant_any && (grant_idx == CH_W'(gi));
        end
    endgenerate

    assign bus.in_ready = grant_vec;

    // Operand select; a clear arriving with the grant makes the datapath see an empty history.
    always_comb begin
        x_sel    = bus.in_data[SAMPLE_W*grant_idx +: SAMPLE_W];
        hist_sel = bus.clr[grant_idx] ? '0 : hist_reg[grant_idx];
    end

    sma_ds2_core u_core (
        .x         (x_sel),
        .hist      (hist_sel),
        .y         (y),
        .hist_next (hist_upd)
    );

    // History banks: granted channel advances, other channels only react to their clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < N_CH; k++) hist_reg[k] <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (grant_any && (grant_idx == CH_W'(k))) hist_reg[k] <= hist_upd;
                else if (bus.clr[k])                      hist_reg[k] <= '0;
            end
        end
    end

    // Single output register and round-robin pointer; a grant in the handshake cycle refills it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_reg <= 1'b0;
            out_ch_reg    <= '0;
            out_data_reg  <= '0;
            rr_last_reg   <= CH_W'(N_CH - 1);
        end else if (grant_any) begin
            out_valid_reg <= 1'b1;
            out_ch_reg    <= grant_idx;
            out_data_reg  <= y;
            rr_last_reg   <= grant_idx;
        end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign bus.out_valid = out_valid_reg;
    assign bus.out_ch    = out_ch_reg;
    assign bus.out_data  = out_data_reg;

endmodule

// File: tb/tb_sma_tdm_scheduler.sv
// Directed test of the round-robin moving-average scheduler.
module tb_sma_tdm_scheduler;
    import sma_pkg::*;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    sma_tdm_scheduler_if #(.N_CH(4), .CH_W(2)) bus ();

    sma_tdm_scheduler #(.N_CH(4), .CH_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int ch, input logic signed [15:0] e);
        chk({tag, ".out_valid"}, {31'd0, bus.out_valid}, 32'd1);
        chk({tag, ".out_ch"},    {30'd0, bus.out_ch},    32'(ch));
        chk({tag, ".out_data"},  {16'd0, bus.out_data},  {16'd0, e});
    endtask

    // One granted sample on a single channel; checks the grant and the result one edge later.
    task automatic send_one(input string tag, input int ch, input logic signed [15:0] x,
                            input logic [3:0] clr_m, input logic signed [15:0] e);
        bus.in_valid = 4'b0001 << ch;
        bus.in_data[16*ch +: 16] = x;
        bus.clr = clr_m;
        #1;
        chk({tag, ".in_ready"}, {28'd0, bus.in_ready}, {28'd0, 4'b0001 << ch});
        @(posedge clk); #1;
        bus.in_valid = '0;
        bus.clr = '0;
        chk_out(tag, ch, e);
        $display("%s ch=%0d x=%0d out=%0d expected=%0d", tag, ch, x, bus.out_data, e);
    endtask

    logic signed [15:0] exp3 [4][4];

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b0;
        bus.in_valid = '0;
        bus.in_data = '0;
        bus.clr = '0;
        bus.out_ready = 1'b1;
        exp3[0] = '{16'sd2, 16'sd5, 16'sd7, 16'sd10};
        exp3[1] = '{-16'sd2, -16'sd4, -16'sd6, -16'sd8};
        exp3[2] = '{16'sd100, 16'sd200, 16'sd300, 16'sd400};
        exp3[3] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};

        // Reset state
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("reset.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset.out_ch", {30'd0, bus.out_ch}, 32'd0);
        chk("reset.out_data", {16'd0, bus.out_data}, 32'd0);
        chk("reset.in_ready", {28'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;

        // Single channel ramp on ch0
        send_one("ramp", 0, 16'sd100, 4'b0000, 16'sd25);
        send_one("ramp", 0, 16'sd200, 4'b0000, 16'sd75);
        send_one("ramp", 0, 16'sd300, 4'b0000, 16'sd150);
        send_one("ramp", 0, 16'sd400, 4'b0000, 16'sd250);
        send_one("ramp", 0, 16'sd500, 4'b0000, 16'sd350);

        // Asynchronous reset while a result is pending and all channels request
        bus.in_valid = 4'b1111;
        #2 rst = 1'b0;
        #1;
        chk("midrst.out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("midrst.out_data", {16'd0, bus.out_data}, 32'd0);
        chk("midrst.in_ready", {28'd0, bus.in_ready}, 32'd0);
        @(posedge clk); #1;
        chk("midrst.in_ready2", {28'd0, bus.in_ready}, 32'd0);
        chk("midrst.out_valid2", {31'd0, bus.out_valid}, 32'd0);
        $display("midrst out_valid=%0d in_ready=%b", bus.out_valid, bus.in_ready);
        rst = 1'b1;

        // All channels valid, round-robin from ch0 with independent histories
        bus.in_data = {16'sd4, 16'sd400, -16'sd8, 16'sd10};
        bus.in_valid = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                #1;
                chk("rr.in_ready", {28'd0, bus.in_ready}, {28'd0, 4'b0001 << c});
                @(posedge clk); #1;
                chk_out("rr", c, exp3[c][r]);
                $display("rr round=%0d ch=%0d out=%0d expected=%0d", r, c, bus.out_data, exp3[c][r]);
            end
        end
        bus.in_valid = '0;

        // Extremes and truncation toward zero on ch2
        send_one("neg", 2, -16'sd32768, 4'b0100, -16'sd8192);
        send_one("neg", 2, -16'sd32768, 4'b0000, -16'sd16384);
        send_one("neg", 2, -16'sd32768, 4'b0000, -16'sd24576);
        send_one("neg", 2, -16'sd32768, 4'b0000, -16'sd32768);
        send_one("pos", 2, 16'sd32767, 4'b0000, -16'sd16384);
        send_one("pos", 2, 16'sd32767, 4'b0000, 16'sd0);
        send_one("pos", 2, 16'sd32767, 4'b0000, 16'sd16383);
        send_one("pos", 2, 16'sd32767, 4'b0000, 16'sd32767);
        send_one("trunc", 2, -16'sd3, 4'b0100, 16'sd0);
        @(posedge clk); #1;
        chk("idle.out_valid", {31'd0, bus.out_valid}, 32'd0);

        // Backpressure: result on ch3 held while the sink stalls
        bus.out_ready = 1'b0;
        send_one("bp", 3, 16'sd8, 4'b0000, 16'sd5);
        bus.in_valid = 4'b1001;
        bus.in_data[15:0] = 16'sd500;
        bus.in_data[63:48] = 16'sd777;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("bp.in_ready", {28'd0, bus.in_ready}, 32'd0);
            @(posedge clk); #1;
            chk_out("bp.hold", 3, 16'sd5);
            $display("bp stall=%0d out_ch=%0d out=%0d in_ready=%b", s, bus.out_ch, bus.out_data, bus.in_ready);
        end
        bus.out_ready = 1'b1;
        send_one("bp.release", 3, 16'sd100, 4'b0000, 16'sd29);
        @(posedge clk); #1;
        chk("bp.drain", {31'd0, bus.out_valid}, 32'd0);

        // Clear with grant on ch1, plus clear of a non-granted channel
        send_one("clr.pre", 1, 16'sd100, 4'b0000, 16'sd19);
        send_one("clr.pre", 1, 16'sd100, 4'b0000, 16'sd46);
        send_one("clr.pre", 1, 16'sd100, 4'b0000, 16'sd73);
        send_one("clr.pre", 1, 16'sd100, 4'b0000, 16'sd100);
        send_one("clr.grant", 1, 16'sd40, 4'b0010, 16'sd10);
        send_one("clr.after", 1, 16'sd40, 4'b1000, 16'sd20);
        send_one("clr.other", 3, 16'sd40, 4'b0000, 16'sd10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
